charge_session_ctrl: RTL and testbench
======================================

# charge_session_ctrl

Sequences one charging session from the host configuration words delivered by the AXI-Lite register block. It latches config on a start command and runs a PRECHARGE/CC/CV state machine driven by ADC samples. It drives the converter enable and current reference, enforces protection limits and timeout, and returns live status as packed statistics words for the register read path.

## Interface
- NUMBER_REG_IN, 9, number of 32-bit host config words in host_data0
- NUMBER_REG_OUT, 10, number of 32-bit statistics words
- TICK_DIV, 100000, aclk cycles per 1 ms tick (min 2)
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- host_data0  in  32*NUMBER_REG_IN  config words w0..w8 (w0 at bits [31:0])
- host_data_valid  in  1  level or pulse; rising edge = new command
- meas_valid  in  1  one-cycle strobe, new ADC sample
- meas_voltage  in  16  battery voltage, mV, unsigned
- meas_current  in  16  charge current, mA, unsigned
- pwm_en  out  1  converter enable
- i_ref  out  16  current reference, mA
- busy  out  1  state is PRECHARGE, CC or CV
- fault  out  1  state is FAULT
- statistics  out  32*NUMBER_REG_OUT  status words s0..s9

## Operation
- Config words (low 16 bits used except w0, w6): w0 command (bit0 start, bit1 abort, bit2 clear), w1 v_pre (precharge exit), w2 v_target, w3 i_cc, w4 i_pre, w5 i_term, w6 timeout_ms (32b, 0 = none), w7 v_max, w8 i_max.
- Command = cycle after a rising edge of host_data_valid (registered edge detect). Level-held valid issues one command. Priority: abort > clear > start.
- States/encoding: IDLE=0, PRECHARGE=1, CC=2, CV=3, DONE=4, FAULT=5.
- start in IDLE or DONE: latch w1..w8 into shadow regs. Invalid config (v_target=0, i_cc=0, or v_target>v_max) -> FAULT code 4. Otherwise clear elapsed/charge/sample counters, increment session count, -> PRECHARGE. start is ignored in other states.
- PRECHARGE: i_ref=i_pre. On meas_valid with voltage>=v_pre -> CC.
- CC: i_ref=i_cc. On meas_valid with voltage>=v_target -> CV.
- CV: on each meas_valid, voltage>v_target and i_ref>0 -> i_ref-1; voltage<v_target and i_ref<i_cc -> i_ref+1. current<=i_term -> DONE.
- Protection, checked on every meas_valid in PRECHARGE/CC/CV before the transitions above: voltage>v_max -> FAULT code 1; else current>i_max -> FAULT code 2. Timeout: elapsed_ms>=timeout_ms, with timeout_ms nonzero -> FAULT code 3. Same-cycle precedence: 1 > 2 > 3 > normal transition.
- abort in any state -> IDLE, fault code cleared. clear applies only in FAULT -> IDLE, code cleared.
- pwm_en=1 only in PRECHARGE/CC/CV. i_ref=0 in IDLE/DONE/FAULT.
- ms tick: free-running counter 0..TICK_DIV-1. On wrap, while busy: elapsed_ms+1 and charge_acc += last current. charge_acc saturates at 0xFFFFFFFF.
- Statistics: s0 state, s1 fault code, s2 elapsed_ms, s3 last voltage, s4 last current, s5 charge_acc (mA·ms), s6 session count (wraps), s7 latched v_target, s8 i_ref, s9 meas sample count while busy (wraps). Upper bits zero-filled.

## Timing
- Reset values: pwm_en=0, i_ref=0, busy=0, fault=0, state IDLE, all statistics 0.
- Command latency: rising edge of host_data_valid at edge N -> state change visible after edge N+2.
- meas_valid at edge N -> state/i_ref/s3/s4 update after edge N+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Tick counter runs in all states. Elapsed and charge counters freeze outside busy and hold their values in DONE/FAULT.
- Reset mid-session: immediate return to reset values. Shadow config is discarded.

## Test plan
- Nominal: v_pre=3000, v_target=4200, i_cc=1000, i_pre=100, i_term=50, v_max=4300, i_max=1500. Feed samples 2900, 3100, 4200, then current 40 -> states 1, 2, 3, 4; i_ref 100, 1000, 1000, 0; s6=1.
- Over-voltage in CC: sample 4350 mV -> FAULT, s1=1, pwm_en=0 one cycle after meas_valid; start ignored; clear -> IDLE, s1=0.
- Timeout: TICK_DIV=4, timeout_ms=3, no samples -> FAULT code 3 after 12 cycles in PRECHARGE; s2=3.
- CV regulation: voltage 4210 ×5 -> i_ref 995; then 4190 ×10 -> i_ref 1000 (clamped at i_cc).
- Invalid config (v_target=4400>v_max) -> FAULT code 4, s6 unchanged. Level-held host_data_valid for 20 cycles -> exactly one command.
- Abort mid-CV, and async reset mid-PRECHARGE -> IDLE, pwm_en=0, i_ref=0; after reset all statistics 0.

Source files
------------

// File: rtl/charge_session_ctrl.sv
// Charging session sequencer: host command -> PRECHARGE/CC/CV regulation with protection and timeout.
// Command acts 2 cycles after host_data_valid rises, ADC sample 1 cycle after meas_valid; no backpressure.
module charge_session_ctrl #(
    parameter int NUMBER_REG_IN  = 9,
    parameter int NUMBER_REG_OUT = 10,
    parameter int TICK_DIV       = 100000
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [32*NUMBER_REG_IN-1:0]  host_data0,
    input  logic                         host_data_valid,
    input  logic                         meas_valid,
    input  logic [15:0]                  meas_voltage,
    input  logic [15:0]                  meas_current,
    output logic                         pwm_en,
    output logic [15:0]                  i_ref,
    output logic                         busy,
    output logic                         fault,
    output logic [32*NUMBER_REG_OUT-1:0] statistics
);
    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        CC        = 3'd2,
        CV        = 3'd3,
        DONE      = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t      state;
    logic [2:0]  fault_code;

    logic        valid_q;
    logic        edge_q;
    logic        cmd_q;

    logic [2:0]  c_cmd;
    logic [15:0] c_v_pre, c_v_target, c_i_cc, c_i_pre, c_i_term, c_v_max, c_i_max;
    logic [31:0] c_timeout;

    logic [15:0] v_pre, v_target, i_cc, i_pre, i_term, v_max, i_max;
    logic [31:0] timeout_ms;

    logic        meas_vld_q;
    logic [15:0] meas_v_q, meas_i_q;
    logic [15:0] last_v, last_i;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_wrap;
    logic [31:0]       elapsed_ms, charge_acc, session_cnt, sample_cnt;
    logic [32:0]       charge_sum;
    logic              cfg_invalid;
    logic              timed_out;
    logic              unused_host_bits;

    assign unused_host_bits = ^host_data0;

    assign busy   = (state == PRECHARGE) || (state == CC) || (state == CV);
    assign fault  = (state == FAULT);
    assign pwm_en = busy;

    assign tick_wrap   = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign charge_sum  = {1'b0, charge_acc} + {17'd0, last_i};
    assign cfg_invalid = (c_v_target == 16'd0) || (c_i_cc == 16'd0) || (c_v_target > c_v_max);
    assign timed_out   = (timeout_ms != 32'd0) && (elapsed_ms >= timeout_ms);

    // Config words are captured on the rising edge of valid so a single-cycle pulse is enough.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q    <= 1'b0;
            edge_q     <= 1'b0;
            cmd_q      <= 1'b0;
            c_cmd      <= '0;
            c_v_pre    <= '0;
            c_v_target <= '0;
            c_i_cc     <= '0;
            c_i_pre    <= '0;
            c_i_term   <= '0;
            c_timeout  <= '0;
            c_v_max    <= '0;
            c_i_max    <= '0;
            meas_vld_q <= 1'b0;
            meas_v_q   <= '0;
            meas_i_q   <= '0;
        end else begin
            valid_q    <= host_data_valid;
            edge_q     <= host_data_valid && !valid_q;
            cmd_q      <= edge_q;
            meas_vld_q <= meas_valid;
            meas_v_q   <= meas_voltage;
            meas_i_q   <= meas_current;
            if (host_data_valid && !valid_q) begin
                c_cmd      <= host_data0[2:0];
                c_v_pre    <= host_data0[32  +: 16];
                c_v_target <= host_data0[64  +: 16];
                c_i_cc     <= host_data0[96  +: 16];
                c_i_pre    <= host_data0[128 +: 16];
                c_i_term   <= host_data0[160 +: 16];
                c_timeout  <= host_data0[192 +: 32];
                c_v_max    <= host_data0[224 +: 16];
                c_i_max    <= host_data0[256 +: 16];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            fault_code  <= '0;
            i_ref       <= '0;
            v_pre       <= '0;
            v_target    <= '0;
            i_cc        <= '0;
            i_pre       <= '0;
            i_term      <= '0;
            timeout_ms  <= '0;
            v_max       <= '0;
            i_max       <= '0;
            last_v      <= '0;
            last_i      <= '0;
            tick_cnt    <= '0;
            elapsed_ms  <= '0;
            charge_acc  <= '0;
            session_cnt <= '0;
            sample_cnt  <= '0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            if (busy && tick_wrap) begin
                elapsed_ms <= elapsed_ms + 32'd1;
                charge_acc <= charge_sum[32] ? 32'hFFFF_FFFF : charge_sum[31:0];
            end
            if (meas_vld_q) begin
                last_v <= meas_v_q;
                last_i <= meas_i_q;
                if (busy)
                    sample_cnt <= sample_cnt + 32'd1;
            end

            if (cmd_q && c_cmd[1]) begin
                state      <= IDLE;
                fault_code <= '0;
                i_ref      <= '0;
            end else if (cmd_q && c_cmd[2] && state == FAULT) begin
                state      <= IDLE;
                fault_code <= '0;
            end else if (cmd_q && c_cmd[0] && (state == IDLE || state == DONE)) begin
                v_pre      <= c_v_pre;
                v_target   <= c_v_target;
                i_cc       <= c_i_cc;
                i_pre      <= c_i_pre;
                i_term     <= c_i_term;
                timeout_ms <= c_timeout;
                v_max      <= c_v_max;
                i_max      <= c_i_max;
                if (cfg_invalid) begin
                    state      <= FAULT;
                    fault_code <= 3'd4;
                    i_ref      <= '0;
                end else begin
                    elapsed_ms  <= '0;
                    charge_acc  <= '0;
                    sample_cnt  <= '0;
                    session_cnt <= session_cnt + 32'd1;
                    state       <= PRECHARGE;
                    i_ref       <= c_i_pre;
                end
            end else if (busy) begin
                // Protection outranks timeout, which outranks the regulation step.
                if (meas_vld_q && meas_v_q > v_max) begin
                    state      <= FAULT;
                    fault_code <= 3'd1;
                    i_ref      <= '0;
                end else if (meas_vld_q && meas_i_q > i_max) begin
                    state      <= FAULT;
                    fault_code <= 3'd2;
                    i_ref      <= '0;
                end else if (timed_out) begin
                    state      <= FAULT;
                    fault_code <= 3'd3;
                    i_ref      <= '0;
                end else if (meas_vld_q) begin
                    case (state)
                        PRECHARGE: begin
                            if (meas_v_q >= v_pre) begin
                                state <= CC;
                                i_ref <= i_cc;
                            end
                        end
                        CC: begin
                            if (meas_v_q >= v_target)
                                state <= CV;
                        end
                        CV: begin
                            if (meas_i_q <= i_term) begin
                                state <= DONE;
                                i_ref <= '0;
                            end else if (meas_v_q > v_target && i_ref != 16'd0) begin
                                i_ref <= i_ref - 16'd1;
                            end else if (meas_v_q < v_target && i_ref < i_cc) begin
                                i_ref <= i_ref + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [31:0] stat_w [10];

    always_comb begin
        stat_w[0] = {29'd0, state};
        stat_w[1] = {29'd0, fault_code};
        stat_w[2] = elapsed_ms;
        stat_w[3] = {16'd0, last_v};
        stat_w[4] = {16'd0, last_i};
        stat_w[5] = charge_acc;
        stat_w[6] = session_cnt;
        stat_w[7] = {16'd0, v_target};
        stat_w[8] = {16'd0, i_ref};
        stat_w[9] = sample_cnt;
    end

    for (genvar k = 0; k < NUMBER_REG_OUT; k++) begin : g_stat
        if (k < 10) begin : g_word
            assign statistics[32*k +: 32] = stat_w[k];
        end else begin : g_zero
            assign statistics[32*k +: 32] = 32'd0;
        end
    end

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Directed bench for charge_session_ctrl, run with a 4-cycle ms tick.
module tb_charge_session_ctrl;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [287:0] host_data0 = '0;
    logic         host_data_valid = 1'b0;
    logic         meas_valid = 1'b0;
    logic [15:0]  meas_voltage = '0;
    logic [15:0]  meas_current = '0;
    logic         pwm_en;
    logic [15:0]  i_ref;
    logic         busy;
    logic         fault;
    logic [319:0] statistics;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    localparam logic [31:0] C_START = 32'd1;
    localparam logic [31:0] C_ABORT = 32'd2;
    localparam logic [31:0] C_CLEAR = 32'd4;

    charge_session_ctrl #(.NUMBER_REG_IN(9), .NUMBER_REG_OUT(10), .TICK_DIV(4)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .host_data0(host_data0),
        .host_data_valid(host_data_valid),
        .meas_valid(meas_valid),
        .meas_voltage(meas_voltage),
        .meas_current(meas_current),
        .pwm_en(pwm_en),
        .i_ref(i_ref),
        .busy(busy),
        .fault(fault),
        .statistics(statistics)
    );

    always #5 aclk = ~aclk;

    function automatic logic [287:0] cfg(input logic [31:0] cmd, input logic [15:0] vpre, vt, icc,
                                         ipre, iterm, input logic [31:0] tmo,
                                         input logic [15:0] vmax, imax);
        cfg = {16'd0, imax, 16'd0, vmax, tmo, 16'd0, iterm, 16'd0, ipre,
               16'd0, icc, 16'd0, vt, 16'd0, vpre, cmd};
    endfunction

    function automatic logic [31:0] sw(input int k);
        sw = statistics[32*k +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [287:0] w);
        host_data0 = w;
        host_data_valid = 1'b1;
        step();
        host_data_valid = 1'b0;
        step();
        step();
    endtask

    task automatic sample(input logic [15:0] v, input logic [15:0] i);
        meas_valid = 1'b1;
        meas_voltage = v;
        meas_current = i;
        step();
        meas_valid = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("rst_i_ref", {16'd0, i_ref}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        for (int k = 0; k < 10; k++) chk($sformatf("rst_s%0d", k), sw(k), 32'd0);
        aresetn = 1'b1;
        step();

        // Nominal session with exact command latency
        host_data0 = cfg(C_START, 3000, 4200, 1000, 100, 50, 0, 4300, 1500);
        host_data_valid = 1'b1;
        step();
        host_data_valid = 1'b0;
        step();
        chk("cmd_lat_early", sw(0), 32'd0);
        step();
        chk("nom_state_pre", sw(0), 32'd1);
        chk("nom_busy", {31'd0, busy}, 32'd1);
        chk("nom_pwm_en", {31'd0, pwm_en}, 32'd1);
        chk("nom_iref_pre", {16'd0, i_ref}, 32'd100);
        chk("nom_s6", sw(6), 32'd1);
        sample(2900, 500);
        chk("nom_stay_pre", sw(0), 32'd1);
        meas_valid = 1'b1;
        meas_voltage = 3100;
        meas_current = 500;
        step();
        meas_valid = 1'b0;
        chk("meas_lat_early", sw(0), 32'd1);
        step();
        chk("nom_state_cc", sw(0), 32'd2);
        chk("nom_iref_cc", {16'd0, i_ref}, 32'd1000);
        sample(4200, 500);
        chk("nom_state_cv", sw(0), 32'd3);
        chk("nom_iref_cv", {16'd0, i_ref}, 32'd1000);
        chk("nom_s3", sw(3), 32'd4200);
        sample(4200, 40);
        chk("nom_state_done", sw(0), 32'd4);
        chk("nom_iref_done", {16'd0, i_ref}, 32'd0);
        chk("nom_pwm_done", {31'd0, pwm_en}, 32'd0);
        chk("nom_s4", sw(4), 32'd40);
        chk("nom_s7", sw(7), 32'd4200);
        chk("nom_s9", sw(9), 32'd4);

        // CV regulation, restart from DONE
        send(cfg(C_START, 3000, 4200, 1000, 100, 50, 0, 4300, 1500));
        chk("cv_s6", sw(6), 32'd2);
        sample(3100, 900);
        sample(4200, 900);
        chk("cv_enter", sw(0), 32'd3);
        repeat (5) sample(4210, 900);
        chk("cv_iref_down", {16'd0, i_ref}, 32'd995);
        repeat (10) sample(4190, 900);
        chk("cv_iref_clamp", {16'd0, i_ref}, 32'd1000);
        chk("cv_s8", sw(8), 32'd1000);

        // Abort mid-CV
        send(cfg(C_ABORT, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("abort_state", sw(0), 32'd0);
        chk("abort_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("abort_iref", {16'd0, i_ref}, 32'd0);

        // Over-voltage in CC (over-current too: voltage fault wins)
        send(cfg(C_START, 3000, 4200, 1000, 100, 50, 0, 4300, 1500));
        sample(3100, 500);
        chk("ov_in_cc", sw(0), 32'd2);
        meas_valid = 1'b1;
        meas_voltage = 4350;
        meas_current = 1600;
        step();
        meas_valid = 1'b0;
        step();
        chk("ov_state", sw(0), 32'd5);
        chk("ov_code", sw(1), 32'd1);
        chk("ov_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("ov_fault", {31'd0, fault}, 32'd1);
        send(cfg(C_START, 3000, 4200, 1000, 100, 50, 0, 4300, 1500));
        chk("ov_start_ign", sw(0), 32'd5);
        chk("ov_s6", sw(6), 32'd3);
        send(cfg(C_CLEAR, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("clr_state", sw(0), 32'd0);
        chk("clr_code", sw(1), 32'd0);

        // Timeout with no samples
        send(cfg(C_START, 3000, 4200, 1000, 100, 50, 3, 4300, 1500));
        chk("tmo_pre", sw(0), 32'd1);
        n = 0;
        while (fault !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("tmo_window", {31'd0, (n >= 10 && n <= 13)}, 32'd1);
        chk("tmo_code", sw(1), 32'd3);
        chk("tmo_s2", sw(2), 32'd3);
        repeat (10) step();
        chk("tmo_s2_frozen", sw(2), 32'd3);
        send(cfg(C_CLEAR, 0, 0, 0, 0, 0, 0, 0, 0));

        // Invalid config, level-held valid
        host_data0 = cfg(C_START, 3000, 4400, 1000, 100, 50, 0, 4300, 1500);
        host_data_valid = 1'b1;
        repeat (20) step();
        host_data_valid = 1'b0;
        step();
        chk("inv_state", sw(0), 32'd5);
        chk("inv_code", sw(1), 32'd4);
        chk("inv_s6", sw(6), 32'd4);
        chk("inv_s7", sw(7), 32'd4400);
        host_data0 = cfg(C_CLEAR | C_START, 3000, 4200, 1000, 100, 50, 0, 4300, 1500);
        host_data_valid = 1'b1;
        repeat (20) step();
        host_data_valid = 1'b0;
        step();
        chk("lvl_one_cmd", sw(0), 32'd0);
        chk("lvl_s6", sw(6), 32'd4);

        // Async reset mid-PRECHARGE
        send(cfg(C_START, 3000, 4200, 1000, 100, 50, 0, 4300, 1500));
        chk("rst2_pre", sw(0), 32'd1);
        chk("rst2_s6", sw(6), 32'd5);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst2_state", sw(0), 32'd0);
        chk("rst2_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("rst2_iref", {16'd0, i_ref}, 32'd0);
        step();
        aresetn = 1'b1;
        step();
        for (int k = 0; k < 10; k++) chk($sformatf("rst2_s%0d", k), sw(k), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
